// File: rtl/hazard_sequencer.sv
// Hazard / sequencing controller for the 5-stage RV32I pipeline.
// Tracks a shadow copy of the E/M/W control fields. It drives stall and
// flush controls, the EX forwarding selects and a memory-wait freeze FSM.
module hazard_sequencer #(
  parameter int REG_W       = 5,
  parameter int CNT_W       = 16,
  parameter int MEM_TIMEOUT = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [REG_W-1:0] Rs1D,
  input  logic [REG_W-1:0] Rs2D,
  input  logic [REG_W-1:0] RdD,
  input  logic             RegWriteD,
  input  logic             LoadD,
  input  logic             MemReqD,
  input  logic             PCSrcE,
  input  logic             MemReadyM,
  output logic             StallF,
  output logic             StallD,
  output logic             StallE,
  output logic             StallM,
  output logic             FlushD,
  output logic             FlushE,
  output logic             FlushW,
  output logic [1:0]       ForwardAE,
  output logic [1:0]       ForwardBE,
  output logic [CNT_W-1:0] stall_cycles,
  output logic             mem_timeout
);

  // Each stage keeps only the fields that are still consumed downstream.
  typedef struct packed {
    logic [REG_W-1:0] rs1;
    logic [REG_W-1:0] rs2;
    logic [REG_W-1:0] rd;
    logic             regWrite;
    logic             load;
    logic             memReq;
  } slotE_t;

  typedef struct packed {
    logic [REG_W-1:0] rd;
    logic             regWrite;
    logic             memReq;
  } slotM_t;

  typedef struct packed {
    logic [REG_W-1:0] rd;
    logic             regWrite;
  } slotW_t;

  typedef enum logic {RUN = 1'b0, MEMWAIT = 1'b1} state_t;

  localparam int               WAIT_W   = $clog2(MEM_TIMEOUT + 1) + 1;
  localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MEM_TIMEOUT);
  localparam logic [CNT_W-1:0]  CNT_MAX  = {CNT_W{1'b1}};

  slotE_t            slotD, slotE;
  slotM_t            slotM;
  slotW_t            slotW;
  state_t            state, stateNext;
  logic [WAIT_W-1:0] waitCnt, waitNext;
  logic              lu, memBusy, freeze;

  // Register 0 is hard-wired zero, so it never sources a forward.
  function automatic logic [1:0] fwdSel(input logic [REG_W-1:0] rs,
                                        input slotM_t m, input slotW_t w);
    if (m.regWrite && m.rd != '0 && m.rd == rs)      return 2'b10;
    else if (w.regWrite && w.rd != '0 && w.rd == rs) return 2'b01;
    else                                             return 2'b00;
  endfunction

  assign slotD   = '{rs1: Rs1D, rs2: Rs2D, rd: RdD,
                     regWrite: RegWriteD, load: LoadD, memReq: MemReqD};
  assign lu      = slotE.load & slotE.regWrite & (slotE.rd != '0) &
                   ((slotE.rd == Rs1D) | (slotE.rd == Rs2D));
  assign memBusy = slotM.memReq & ~MemReadyM;
  // Freeze starts in the same cycle the M access is seen stalling, and lasts
  // until memory reports ready. Reset drops it immediately.
  assign freeze  = ~rst & ((state == RUN) ? memBusy : ~MemReadyM);
  // Freeze-cycle count including the current cycle, saturating.
  assign waitNext = (state == RUN) ? WAIT_W'(1) :
                    (waitCnt < WAIT_MAX) ? waitCnt + 1'b1 : waitCnt;

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) state <= RUN;
    else     state <= stateNext;
  end

  // FSM next-state logic
  always_comb begin
    stateNext = state;
    case (state)
      RUN:     if (memBusy)   stateNext = MEMWAIT;
      MEMWAIT: if (MemReadyM) stateNext = RUN;
      default: stateNext = RUN;
    endcase
  end

  // FSM outputs: freeze beats redirect; redirect beats load-use
  always_comb begin
    StallF    = 1'b0;
    StallD    = 1'b0;
    StallE    = 1'b0;
    StallM    = 1'b0;
    FlushD    = 1'b0;
    FlushE    = 1'b0;
    FlushW    = 1'b0;
    ForwardAE = 2'b00;
    ForwardBE = 2'b00;
    if (rst) begin
      FlushD = 1'b1;
      FlushE = 1'b1;
    end else begin
      ForwardAE = fwdSel(slotE.rs1, slotM, slotW);
      ForwardBE = fwdSel(slotE.rs2, slotM, slotW);
      if (freeze) begin
        StallF = 1'b1;
        StallD = 1'b1;
        StallE = 1'b1;
        StallM = 1'b1;
        FlushW = 1'b1;
      end else if (state == RUN) begin
        if (PCSrcE) begin
          FlushD = 1'b1;
          FlushE = 1'b1;
        end else if (lu) begin
          StallF = 1'b1;
          StallD = 1'b1;
          FlushE = 1'b1;
        end
      end
    end
  end

  // Shadow pipeline: E/M/W mirror the real pipeline registers' fate
  always_ff @(posedge clk) begin
    if (rst) begin
      slotE <= '0;
      slotM <= '0;
      slotW <= '0;
    end else begin
      if (FlushE)       slotE <= '0;
      else if (!StallE) slotE <= slotD;
      if (!StallM)      slotM <= '{rd: slotE.rd, regWrite: slotE.regWrite,
                                   memReq: slotE.memReq};
      if (FlushW)       slotW <= '0;
      else              slotW <= '{rd: slotM.rd, regWrite: slotM.regWrite};
    end
  end

  // Memory-wait length tracking and sticky timeout flag
  always_ff @(posedge clk) begin
    if (rst) begin
      waitCnt     <= '0;
      mem_timeout <= 1'b0;
    end else if (freeze) begin
      waitCnt <= waitNext;
      if (waitNext >= WAIT_MAX) mem_timeout <= 1'b1;
    end else begin
      waitCnt <= '0;
    end
  end

  // Saturating count of front-end stall cycles
  always_ff @(posedge clk) begin
    if (rst)                                  stall_cycles <= '0;
    else if (StallF && stall_cycles != CNT_MAX) stall_cycles <= stall_cycles + 1'b1;
  end

endmodule
